// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, field widths and small timing helpers
// for the pixel RAM scan-out path.
package vga_timing_pkg;

  localparam int   DEF_H_ACTIVE    = 640;
  localparam int   DEF_H_FP        = 16;
  localparam int   DEF_H_SYNC      = 96;
  localparam int   DEF_H_BP        = 48;
  localparam int   DEF_V_ACTIVE    = 480;
  localparam int   DEF_V_FP        = 10;
  localparam int   DEF_V_SYNC      = 2;
  localparam int   DEF_V_BP        = 33;
  localparam int   DEF_BLOCK_SHIFT = 3;
  localparam logic DEF_SYNC_POL    = 1'b0;

  localparam int CNT_W = 10;
  localparam int COL_W = 7;
  localparam int ROW_W = 6;
  localparam int RGB_W = 4;
  localparam int PIX_W = 3 * RGB_W;

  function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  function automatic logic sync_level(input logic in_window, input logic pol);
    return in_window ? pol : ~pol;
  endfunction

  localparam int DEF_H_TOTAL = scan_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);

endpackage

// File: rtl/pixel_scan_reader_scan_counter.sv
// Modulo-N counter with increment enable and a combinational wrap pulse that is
// high on the enabled cycle where the count returns to zero.
module scan_counter
  import vga_timing_pkg::*;
#(
  parameter int N = DEF_H_TOTAL,
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_scan_reader.sv
// VGA scan-out from the block-organised pixel RAM: issues block addresses from
// the raster counters and aligns sync/blanking with the RAM's one-cycle read data.
module pixel_scan_reader
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter int   BLOCK_SHIFT = DEF_BLOCK_SHIFT,
  parameter logic SYNC_POL    = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] din,
  output logic [COL_W-1:0] read_col_addr,
  output logic [ROW_W-1:0] read_row_addr,
  output logic             rdn,
  output logic             hs,
  output logic             vs,
  output logic [RGB_W-1:0] r,
  output logic [RGB_W-1:0] g,
  output logic [RGB_W-1:0] b,
  output logic             vblank,
  output logic             frame_tick
);

  localparam int H_TOTAL  = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

  function automatic logic [PIX_W-1:0] blank_pixel(input logic vld, input logic [PIX_W-1:0] pix);
    return vld ? pix : '0;
  endfunction

  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;
  logic             h_wrap_p0;
  logic             v_wrap_p0;
  logic             active_p0;
  logic             hs_win_p0;
  logic             vs_win_p0;
  logic             vbl_p0;
  logic             vld_p1;

  scan_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (h_cnt_p0),
    .wrap  (h_wrap_p0)
  );

  scan_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap_p0),
    .count (v_cnt_p0),
    .wrap  (v_wrap_p0)
  );

  // Stage 0: raster position, RAM address and read strobe
  assign active_p0 = (h_cnt_p0 < CNT_W'(H_ACTIVE)) && (v_cnt_p0 < CNT_W'(V_ACTIVE));
  assign hs_win_p0 = (h_cnt_p0 >= CNT_W'(HS_START)) && (h_cnt_p0 < CNT_W'(HS_END));
  assign vs_win_p0 = (v_cnt_p0 >= CNT_W'(VS_START)) && (v_cnt_p0 < CNT_W'(VS_END));

  assign read_col_addr = COL_W'(h_cnt_p0 >> BLOCK_SHIFT);
  assign read_row_addr = ROW_W'(v_cnt_p0 >> BLOCK_SHIFT);
  // Reads stay disabled while reset is held even though the counters sit at (0,0).
  assign rdn = rst | ~active_p0;

  // Tracks v_cnt >= V_ACTIVE from counter events instead of a magnitude compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      vbl_p0 <= 1'b0;
    end else if (v_wrap_p0) begin
      vbl_p0 <= 1'b0;
    end else if (h_wrap_p0 && (v_cnt_p0 == CNT_W'(V_ACTIVE - 1))) begin
      vbl_p0 <= 1'b1;
    end
  end

  // Stage 1: aligned with RAM read data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      hs         <= sync_level(1'b0, SYNC_POL);
      vs         <= sync_level(1'b0, SYNC_POL);
      vblank     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vld_p1     <= active_p0;
      hs         <= sync_level(hs_win_p0, SYNC_POL);
      vs         <= sync_level(vs_win_p0, SYNC_POL);
      vblank     <= vbl_p0;
      frame_tick <= vbl_p0 & ~vblank;
    end
  end

  assign {r, g, b} = blank_pixel(vld_p1, din);

endmodule

// File: tb/tb_pixel_scan_reader.sv
// Bench for pixel_scan_reader: full-width lines with a shortened frame, random
// RAM contents, address-pattern and constant-white RAM modes, and a mid-frame reset.
module tb_pixel_scan_reader;

  localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
  localparam int VA = 16, VF = 2, VSW = 2, VB = 4;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] din = '0;
  logic [6:0]  read_col_addr;
  logic [5:0]  read_row_addr;
  logic        rdn, hs, vs, vblank, frame_tick;
  logic [3:0]  r, g, b;
  logic [11:0] rgb;

  assign rgb = {r, g, b};

  always #5 clk = ~clk;

  pixel_scan_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .read_col_addr (read_col_addr),
    .read_row_addr (read_row_addr),
    .rdn           (rdn),
    .hs            (hs),
    .vs            (vs),
    .r             (r),
    .g             (g),
    .b             (b),
    .vblank        (vblank),
    .frame_tick    (frame_tick)
  );

  logic [11:0] mem [0:8191];
  int mode = 0;

  // mode 0: random RAM, mode 1: address pattern, mode 2: constant white
  function automatic logic [11:0] pix(input int m, input logic [5:0] row, input logic [6:0] col);
    if (m == 0) return mem[{row, col}];
    if (m == 1) return {row[4:0], col};
    return 12'hFFF;
  endfunction

  // One-cycle-latency RAM read port
  always @(posedge clk) din <= pix(mode, read_row_addr, read_col_addr);

  int checks = 0;
  int errors = 0;
  int n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, n);
    end
  endtask

  int rdn_fall, hs_fall, vs_fall, vb_rise, tick_last;
  int ticks = 0, ticks_exp = 0;
  int lit, lit_line;
  bit lit_on;
  logic hs_q, vs_q, vb_q, rdn_q;

  task automatic fill_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 12'($urandom);
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      int x, y, px, py;
      bit act, pact;
      logic hs_e, vs_e, vb_e, tk_e;
      logic [11:0] rgb_e;
      logic [12:0] adr_e, adr_o;
      @(negedge clk);
      x = n % HT;
      y = (n / HT) % VT;
      act = (x < HA) && (y < VA);
      adr_e = act ? {6'(y >> 3), 7'(x >> 3)} : 13'd0;
      adr_o = rdn ? 13'd0 : {read_row_addr, read_col_addr};
      px = 0; py = 0; pact = 1'b0;
      if (n == 0) begin
        hs_e = 1'b1; vs_e = 1'b1; vb_e = 1'b0; tk_e = 1'b0; rgb_e = '0;
        rdn_fall = -1; hs_fall = -1; vs_fall = -1; vb_rise = -1; tick_last = -1;
        lit = 0; lit_on = 1'b0; lit_line = 0;
        chk("restart", {rdn, read_row_addr, read_col_addr, hs, vs, vblank, frame_tick, rgb},
            {14'd0, 4'b1100, 12'd0});
      end else begin
        px = (n - 1) % HT;
        py = ((n - 1) / HT) % VT;
        pact = (px < HA) && (py < VA);
        hs_e = !((px >= HA + HF) && (px < HA + HF + HSW));
        vs_e = !((py >= VA + VF) && (py < VA + VF + VSW));
        vb_e = (py >= VA);
        tk_e = (py == VA) && (px == 0);
        rgb_e = pact ? pix(mode, 6'(py >> 3), 7'(px >> 3)) : 12'd0;
      end
      if (tk_e) ticks_exp++;
      chk("outs", {2'b00, rdn, adr_o, hs, vs, vblank, frame_tick, rgb},
          {2'b00, !act, adr_e, hs_e, vs_e, vb_e, tk_e, rgb_e});

      if (mode == 1 && n > 0 && py == 9 && px == 17) chk("pix_17_9", rgb, 12'h082);
      if (mode == 1 && n > 0 && py == 9 && px >= 8 && px <= 15) chk("col1_share", rgb[6:0], 1);
      if (x == HA - 1 && y == 5) chk("last_px", {rdn, read_col_addr}, {1'b0, 7'd79});
      if (x == HA && y == 5) chk("blank_rdn", rdn, 1);
      if (n > 0 && x == 0 && y == 0) chk("frame_wrap", {rdn, read_row_addr, read_col_addr}, 0);

      if (x == 1) begin
        if (lit_on) chk("lit_line", lit, (lit_line < VA) ? HA : 0);
        lit = 0;
        lit_on = (mode == 2);
        lit_line = y;
      end
      if (rgb == 12'hFFF) lit++;

      if (n > 0) begin
        if (rdn_q && !rdn) rdn_fall = n;
        if (hs_q && !hs) begin
          if (rdn_fall >= 0) chk("hs_start", n - rdn_fall, HA + HF + 1);
          rdn_fall = -1;
          if (hs_fall >= 0) chk("line_period", n - hs_fall, HT);
          hs_fall = n;
        end
        if (!hs_q && hs && hs_fall >= 0) chk("hs_width", n - hs_fall, HSW);
        if (vs_q && !vs) begin
          if (vs_fall >= 0) chk("vs_period", n - vs_fall, FRAME);
          vs_fall = n;
        end
        if (!vs_q && vs && vs_fall >= 0) chk("vs_width", n - vs_fall, VSW * HT);
        if (!vb_q && vblank) begin
          chk("tick_on_vb_rise", frame_tick, 1);
          vb_rise = n;
        end
        if (vb_q && !vblank && vb_rise >= 0) chk("vblank_len", n - vb_rise, (VT - VA) * HT);
        if (frame_tick) begin
          ticks++;
          if (tick_last >= 0) chk("frame_period", n - tick_last, FRAME);
          tick_last = n;
        end
      end
      hs_q = hs; vs_q = vs; vb_q = vblank; rdn_q = rdn;
      n++;
    end
  endtask

  initial begin
    fill_mem();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_hs", hs, 1);
      chk("rst_vs", vs, 1);
      chk("rst_rgb", rgb, 0);
      chk("rst_rdn", rdn, 1);
      chk("rst_vblank", vblank, 0);
      chk("rst_tick", frame_tick, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;

    run(FRAME - 400);
    chk("tick_count_f1", ticks, 1);
    mode = 1;
    run(FRAME);
    mode = 2;
    run(2 * FRAME + 10 * HT + 300 + 1 - n);

    rst = 1'b1;
    mode = 0;
    fill_mem();
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    run(FRAME + 100);
    chk("tick_count", ticks, ticks_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
